// File: rtl/cam_pkg.sv
// Shared types and constants for the LRU-replacement CAM.
package cam_pkg;

   typedef enum logic [0:0] {
      CAM_IDLE  = 1'b0,
      CAM_FLUSH = 1'b1
   } cam_state_e;

   localparam int STATS_W = 32;

endpackage

// File: rtl/cam_lru_age.sv
// Per-entry age permutation; age 0 is MRU, age WORDS-1 is LRU.
// Two touch ports are applied in order: port a (lookup hit), then port b (fill).
module cam_lru_age #(
   parameter int WORDS = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     touch_a,
   input  logic [$clog2(WORDS)-1:0] idx_a,
   input  logic                     touch_b,
   input  logic [$clog2(WORDS)-1:0] idx_b,
   output logic [$clog2(WORDS)-1:0] lru_idx
);

   localparam int IW = $clog2(WORDS);

   logic [IW-1:0] age_q [WORDS];
   logic [IW-1:0] age_m [WORDS];
   logic [IW-1:0] age_d [WORDS];
   logic [IW-1:0] old_a;
   logic [IW-1:0] old_b;

   always_comb begin
      old_a = age_q[idx_a];
      for (int i = 0; i < WORDS; i++) begin
         age_m[i] = age_q[i];
         if (touch_a) begin
            if (IW'(i) == idx_a)
               age_m[i] = '0;
            else if (age_q[i] < old_a)
               age_m[i] = age_q[i] + 1'b1;
         end
      end
      // the fill sees the lookup's update so it ends up MRU
      old_b = age_m[idx_b];
      for (int i = 0; i < WORDS; i++) begin
         age_d[i] = age_m[i];
         if (touch_b) begin
            if (IW'(i) == idx_b)
               age_d[i] = '0;
            else if (age_m[i] < old_b)
               age_d[i] = age_m[i] + 1'b1;
         end
      end
   end

   always_comb begin
      lru_idx = '0;
      for (int i = 0; i < WORDS; i++)
         if (age_q[i] == IW'(WORDS - 1))
            lru_idx = IW'(i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WORDS; i++)
            age_q[i] <= IW'(i);
      end else begin
         for (int i = 0; i < WORDS; i++)
            age_q[i] <= age_d[i];
      end
   end

endmodule

// File: rtl/cam_lru.sv
// Content-addressable tag/data store with LRU replacement and sequential flush.
// Optional CAM_LRU_STATS_EN adds saturating hit/miss lookup counters.
module cam_lru
   import cam_pkg::*;
#(
   parameter int WORDS  = 8,
   parameter int BITS   = 8,
   parameter int TAG_SZ = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     lookup,
   input  logic [TAG_SZ-1:0]        check_tag,
   output logic [BITS-1:0]          data,
   output logic                     found_it,
   output logic [$clog2(WORDS)-1:0] hit_index,
   input  logic                     fill,
   input  logic [TAG_SZ-1:0]        new_tag,
   input  logic [BITS-1:0]          wdata,
   input  logic                     inval,
   input  logic                     flush,
   output logic                     busy
`ifdef CAM_LRU_STATS_EN
   ,
   output logic [STATS_W-1:0]       hit_count,
   output logic [STATS_W-1:0]       miss_count
`endif
);

   localparam int IW = $clog2(WORDS);

   logic [TAG_SZ-1:0] tag_mem  [WORDS];
   logic [BITS-1:0]   data_mem [WORDS];

   logic [WORDS-1:0]  valid_q, valid_d;
   cam_state_e        state_q;
   logic [IW-1:0]     flush_idx_q;
   logic              busy_q;

   logic [BITS-1:0]   data_q, data_d;
   logic              found_q, found_d;
   logic [IW-1:0]     hidx_q, hidx_d;

   logic              idle;
   logic              lk_hit, fm_hit, free_found;
   logic [IW-1:0]     lk_idx, fm_idx, free_idx, fill_idx, lru_idx;
   logic              do_hit, do_fill, do_inval;

   assign idle = (state_q == CAM_IDLE);

   always_comb begin
      lk_hit     = 1'b0;
      lk_idx     = '0;
      fm_hit     = 1'b0;
      fm_idx     = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (!lk_hit && valid_q[i] && tag_mem[i] == check_tag) begin
            lk_hit = 1'b1;
            lk_idx = IW'(i);
         end
         if (!fm_hit && valid_q[i] && tag_mem[i] == new_tag) begin
            fm_hit = 1'b1;
            fm_idx = IW'(i);
         end
         if (!free_found && !valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
   end

   // flush beats fill beats inval; nothing is accepted mid-flush
   assign do_hit   = idle && lookup && lk_hit;
   assign do_fill  = idle && fill && !flush;
   assign do_inval = idle && inval && !flush && !fill && fm_hit;
   assign fill_idx = fm_hit ? fm_idx : (free_found ? free_idx : lru_idx);

   always_comb begin
      valid_d = valid_q;
      if (do_fill)
         valid_d[fill_idx] = 1'b1;
      if (do_inval)
         valid_d[fm_idx] = 1'b0;
      if (state_q == CAM_FLUSH)
         valid_d[flush_idx_q] = 1'b0;
   end

   always_comb begin
      data_d  = '0;
      found_d = 1'b0;
      hidx_d  = hidx_q;
      if (do_hit) begin
         data_d  = data_mem[lk_idx];
         found_d = 1'b1;
         hidx_d  = lk_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (do_fill) begin
         tag_mem[fill_idx]  <= new_tag;
         data_mem[fill_idx] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         data_q  <= '0;
         found_q <= 1'b0;
         hidx_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         found_q <= found_d;
         hidx_q  <= hidx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CAM_IDLE;
         flush_idx_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            CAM_IDLE: begin
               if (flush) begin
                  state_q     <= CAM_FLUSH;
                  flush_idx_q <= '0;
                  busy_q      <= 1'b1;
               end
            end
            CAM_FLUSH: begin
               if (flush_idx_q == IW'(WORDS - 1)) begin
                  state_q     <= CAM_IDLE;
                  flush_idx_q <= '0;
                  busy_q      <= 1'b0;
               end else begin
                  flush_idx_q <= flush_idx_q + 1'b1;
               end
            end
            default: begin
               state_q     <= CAM_IDLE;
               flush_idx_q <= '0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   cam_lru_age #(.WORDS(WORDS)) u_age (
      .clk     (clk),
      .rst     (rst),
      .touch_a (do_hit),
      .idx_a   (lk_idx),
      .touch_b (do_fill),
      .idx_b   (fill_idx),
      .lru_idx (lru_idx)
   );

   assign data      = data_q;
   assign found_it  = found_q;
   assign hit_index = hidx_q;
   assign busy      = busy_q;

`ifdef CAM_LRU_STATS_EN
   logic [STATS_W-1:0] hit_cnt_q, hit_cnt_d;
   logic [STATS_W-1:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (idle && lookup) begin
         if (lk_hit) begin
            if (hit_cnt_q != '1)
               hit_cnt_d = hit_cnt_q + 1'b1;
         end else if (miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/cam_lru.md
CAM_LRU -- requirements
Module: cam_lru

Interface
REQ-001 The block SHALL have parameter WORDS, default 8, meaning the number of entries (power of two, 2 to 64).
REQ-002 The block SHALL have parameter BITS, default 8, meaning data bits per entry.
REQ-003 The block SHALL have parameter TAG_SZ, default 8, meaning tag bits per entry.
REQ-004 The block SHALL have port clk, input, 1 bit: the system clock; it is the single clock and all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the system reset, synchronous and active-high.
REQ-006 The block SHALL have these ports: lookup in 1 (lookup request); check_tag in TAG_SZ (tag to match).
REQ-007 The block SHALL have these ports: data out BITS (hit data); found_it out 1 (hit); hit_index out clog2(WORDS) (matching or filled entry).
REQ-008 The block SHALL have these ports: fill in 1 (write request); new_tag in TAG_SZ; wdata in BITS.
REQ-009 The block SHALL have these ports: inval in 1 (invalidate entry matching new_tag); flush in 1 (invalidate all); busy out 1 (flush in progress).

Function
REQ-010 Lookup SHALL have 1-cycle latency: data, found_it and hit_index are registered and valid the cycle after lookup is high.
REQ-011 Lookup SHALL see pre-edge contents: a fill to the same tag in the same cycle returns a miss.
REQ-012 On a miss, or when lookup is low, the block SHALL drive data to 0 and found_it to 0 and SHALL hold hit_index.
REQ-013 Fill SHALL follow this rule: if new_tag matches a valid entry, that entry's data is overwritten; otherwise the lowest-index invalid entry is written; if all entries are valid, the LRU entry is written.
REQ-014 Each entry SHALL hold an age in the range 0..WORDS-1, and the ages SHALL always form a permutation; the LRU entry is the one with age WORDS-1.
REQ-015 On a lookup hit or a fill of entry k, the age of k SHALL become 0 and every entry with age less than old age(k) SHALL increment; all other ages hold.
REQ-016 When a lookup hit and a fill target different entries in the same cycle, the fill SHALL update ages last (it becomes MRU).
REQ-017 Inval SHALL clear the valid bit of the entry matching new_tag one cycle later; ages are unchanged; a miss is a no-op.
REQ-018 Request priority SHALL be flush > fill > inval; lower-priority requests in the same cycle are dropped.
REQ-019 The FSM SHALL have states IDLE and FLUSH; flush in IDLE moves to FLUSH and clears one entry per cycle (index 0 upward), returning to IDLE after WORDS cycles.
REQ-020 Busy SHALL be high for exactly the WORDS cycles spent in FLUSH.
REQ-021 While busy, lookup SHALL return a miss and fill, inval and flush SHALL be ignored.

Reset
REQ-022 When rst is high at a clock edge, the block SHALL clear all valid bits, set age(i)=i, enter IDLE, and drive data=0, found_it=0, hit_index=0 and busy=0.
REQ-023 Reset SHALL take effect even mid-flush, and the flush SHALL NOT resume afterwards.
REQ-024 Data and tag memories SHALL NOT require reset.

Configuration
REQ-025 With CAM_LRU_STATS_EN defined, the block SHALL add outputs hit_count and miss_count, each 32 bits, counting lookups (not while busy).
REQ-026 With CAM_LRU_STATS_EN defined, hit_count and miss_count SHALL saturate at all-ones and SHALL be cleared only by rst.
REQ-027 Without CAM_LRU_STATS_EN defined, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 Shared package cam_pkg SHALL hold the FSM state enum (CAM_IDLE, CAM_FLUSH) and the stats counter width constant.
REQ-029 Age tracking SHALL be a sub-module cam_lru_age: it takes touch and index inputs and outputs the LRU index, is reset to age(i)=i, and is cleared by neither flush nor inval.

Verification
REQ-030 The bench SHALL cover: after reset, fill tags 0x10..0x17 with data 0xA0..0xA7, then lookup 0x13 -> next cycle found_it=1, data=0xA3, hit_index=3.
REQ-031 The bench SHALL cover: with the CAM full from REQ-030, lookup 0x10, then fill 0x20 with data 0x55 -> entry 1 is replaced; lookup 0x11 misses and lookup 0x20 hits with hit_index=1.
REQ-032 The bench SHALL cover: fill of existing tag 0x14 with data 0x99 -> no new entry is used; lookup 0x14 returns 0x99 at hit_index 4.
REQ-033 The bench SHALL cover: inval 0x15, then fill 0x30 -> 0x30 is written to entry 5 (lowest invalid), not to the LRU entry.
REQ-034 The bench SHALL cover: flush -> busy is high for exactly 8 cycles, a fill and a lookup issued during busy are ignored and miss, and all lookups miss afterwards.
REQ-035 The bench SHALL cover: rst asserted on the 3rd flush cycle -> next cycle busy=0, all entries are invalid, and the ages read back as 0..7.
